// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the fifo write arbiter.
// Optional feature macro used by the top: FIFO_ARB_PRIORITY_EN.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_MAX_BURST  = 4;

    // Grant index width; a single requester still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer-side handshake, fifo write port and grant status of the write arbiter.
interface fifo_write_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned GRANT_W    = idx_width(NUM_REQ)
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_write_enable;
    logic [DATA_WIDTH-1:0]         fifo_write_data;
    logic                          grant_valid;
    logic [GRANT_W-1:0]            grant_id;

    modport master (
        input  req_valid,
        input  req_data,
        input  fifo_full,
        output req_ready,
        output fifo_write_enable,
        output fifo_write_data,
        output grant_valid,
        output grant_id
    );

    modport slave (
        output req_valid,
        output req_data,
        output fifo_full,
        input  req_ready,
        input  fifo_write_enable,
        input  fifo_write_data,
        input  grant_valid,
        input  grant_id
    );

endinterface

// File: rtl/fifo_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requesting index after i_last, wrapping.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_any
);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;

    // Scan starts one past the previous winner so it is considered last.
    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            w_idx = IDX_W'((32'(i_last) + off) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                w_found  = 1'b1;
                o_winner = w_idx;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded sharing of one fifo write port among NUM_REQ producers.
// Define FIFO_ARB_PRIORITY_EN to make requester 0 a strict high-priority client.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_write_arbiter_if.master bus
);

    localparam int unsigned GRANT_W = idx_width(NUM_REQ);
    localparam int unsigned CNT_W   = cnt_width(MAX_BURST);

    arb_state_e         r_state,       w_state_nxt;
    logic               r_grant_valid, w_grant_valid_nxt;
    logic [GRANT_W-1:0] r_grant_id,    w_grant_id_nxt;
    logic [GRANT_W-1:0] r_last_grant,  w_last_grant_nxt;
    logic [CNT_W-1:0]   r_beat_cnt,    w_beat_cnt_nxt;

    logic [NUM_REQ-1:0]    w_rr_req;
    logic [GRANT_W-1:0]    w_rr_winner;
    logic                  w_rr_any;
    logic [GRANT_W-1:0]    w_win_idx;
    logic                  w_win_any;
    logic                  w_win_upd_last;
    logic                  w_g_valid;
    logic [DATA_WIDTH-1:0] w_g_data;
    logic [NUM_REQ-1:0]    w_req_ready;
    logic                  w_write_enable;
    logic [DATA_WIDTH-1:0] w_write_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GRANT_W)
    ) u_rr_arbiter (
        .i_req    (w_rr_req),
        .i_last   (r_last_grant),
        .o_winner (w_rr_winner),
        .o_any    (w_rr_any)
    );

`ifdef FIFO_ARB_PRIORITY_EN
    // Requester 0 bypasses the rotation and leaves last_grant untouched.
    assign w_rr_req       = bus.req_valid & ~NUM_REQ'(1);
    assign w_win_any      = bus.req_valid[0] | w_rr_any;
    assign w_win_idx      = bus.req_valid[0] ? '0 : w_rr_winner;
    assign w_win_upd_last = !bus.req_valid[0];
`else
    assign w_rr_req       = bus.req_valid;
    assign w_win_any      = w_rr_any;
    assign w_win_idx      = w_rr_winner;
    assign w_win_upd_last = 1'b1;
`endif

    assign w_g_valid = bus.req_valid[r_grant_id];

    // Data slice of the granted producer.
    always_comb begin
        w_g_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == GRANT_W'(i)) begin
                w_g_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_last_grant  <= GRANT_W'(NUM_REQ - 1);
            r_beat_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_last_grant  <= w_last_grant_nxt;
            r_beat_cnt    <= w_beat_cnt_nxt;
        end
    end

    // Next state and write-port decode; a full fifo stalls the burst without ending it.
    always_comb begin
        w_state_nxt       = r_state;
        w_grant_valid_nxt = r_grant_valid;
        w_grant_id_nxt    = r_grant_id;
        w_last_grant_nxt  = r_last_grant;
        w_beat_cnt_nxt    = r_beat_cnt;
        w_req_ready       = '0;
        w_write_enable    = 1'b0;
        w_write_data      = '0;

        case (r_state)
            IDLE: begin
                if (w_win_any) begin
                    w_state_nxt       = BURST;
                    w_grant_valid_nxt = 1'b1;
                    w_grant_id_nxt    = w_win_idx;
                    w_beat_cnt_nxt    = '0;
                    if (w_win_upd_last) begin
                        w_last_grant_nxt = w_win_idx;
                    end
                end
            end
            BURST: begin
                w_req_ready[r_grant_id] = !bus.fifo_full;
                w_write_enable          = w_g_valid & !bus.fifo_full;
                w_write_data            = w_write_enable ? w_g_data : '0;
                if (!w_g_valid) begin
                    w_state_nxt       = IDLE;
                    w_grant_valid_nxt = 1'b0;
                    w_beat_cnt_nxt    = '0;
                end else if (w_write_enable) begin
                    if (r_beat_cnt == CNT_W'(MAX_BURST - 1)) begin
                        w_state_nxt       = IDLE;
                        w_grant_valid_nxt = 1'b0;
                        w_beat_cnt_nxt    = '0;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt       = IDLE;
                w_grant_valid_nxt = 1'b0;
            end
        endcase
    end

    assign bus.req_ready         = w_req_ready;
    assign bus.fifo_write_enable = w_write_enable;
    assign bus.fifo_write_data   = w_write_data;
    assign bus.grant_valid       = r_grant_valid;
    assign bus.grant_id          = r_grant_id;

endmodule
